fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares the write port of one fifo_top instance between NUM_REQ independent producers. Each producer presents data with a valid/ready handshake. The arbiter grants at most one producer per cycle and drives a registered FIFO write strobe. It keeps its own occupancy count so it never writes into a full FIFO. It sits directly in front of the FIFO write port and observes the FIFO read strobe to free space.

---
 rtl/fifo_wr_arbiter_pkg.sv | 21 ++
 rtl/fifo_wr_arbiter_if.sv | 42 ++++
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter and its picker.
// The optional burst feature is selected with the FIFO_WR_ARB_BURST_EN macro.
package fifo_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Width of a producer index (at least 1 bit)
   function automatic int calc_req_idx_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Width of an occupancy counter that must reach DEPTH inclusive
   function automatic int calc_occ_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer handshake, FIFO write/pop and status signals.
// Handshake: a beat moves on a rising edge where req_valid[i] & req_ready[i];
// a producer keeps valid and data stable until it sees ready, and ready never
// depends combinationally on anything except registered state and req_valid.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int DEPTH      = 16
) ();
   import fifo_arb_pkg::*;

   localparam int REQ_IDX_W = calc_req_idx_w(NUM_REQ);
   localparam int OCC_W     = calc_occ_w(DEPTH);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_lock;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_rd_en;
   logic [OCC_W-1:0]              occupancy;
   logic                          full;
   logic [REQ_IDX_W-1:0]          grant_id;
   logic                          underflow_err;
   logic [0:0]                    arb_state;

   // Arbiter side
   modport slave (
      input  req_valid, req_lock, req_data, fifo_rd_en,
      output req_ready, fifo_wr_en, fifo_wr_data, occupancy, full,
             grant_id, underflow_err, arb_state
   );

   // Producer / FIFO side
   modport master (
      output req_valid, req_lock, req_data, fifo_rd_en,
      input  req_ready, fifo_wr_en, fifo_wr_data, occupancy, full,
             grant_id, underflow_err, arb_state
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching cyclically. Returns a one-hot grant, its index and an any flag.
module fifo_rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]                        req,
   input  logic [calc_req_idx_w(NUM_REQ)-1:0]        ptr,
   output logic [NUM_REQ-1:0]                        gnt,
   output logic [calc_req_idx_w(NUM_REQ)-1:0]        idx,
   output logic                                      any
);
   localparam int REQ_IDX_W = calc_req_idx_w(NUM_REQ);

   // Cyclic priority search starting from the pointer
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = REQ_IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter in front of a single FIFO write port.
// Tracks its own occupancy so it never writes into a full FIFO, and registers
// the write strobe/data (one cycle of latency).
// Build option: FIFO_WR_ARB_BURST_EN enables req_lock bursts (BURST state);
// without it req_lock is ignored and arbitration is pure per-beat round-robin.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int DEPTH      = 16,
   parameter int MAX_BURST  = 4
) (
   input logic               clk,
   input logic               rst,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int REQ_IDX_W = calc_req_idx_w(NUM_REQ);
   localparam int OCC_W     = calc_occ_w(DEPTH);
   localparam int BEAT_W    = $clog2(MAX_BURST + 1);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_BURST = BURST;

   logic [0:0]            state_q, state_d;
   logic [REQ_IDX_W-1:0]  ptr_q, ptr_d;
   logic [REQ_IDX_W-1:0]  owner_q, owner_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [REQ_IDX_W-1:0]  grant_id_q, grant_id_d;
   logic                  underflow_q, underflow_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [REQ_IDX_W-1:0]  pick_idx;
   logic                  pick_any;
   logic [NUM_REQ-1:0]    ready;
   logic [NUM_REQ-1:0]    lock_vec;
   logic [REQ_IDX_W-1:0]  win_idx;
   logic                  xfer;
   logic                  pop;
   logic                  full_now;

`ifdef FIFO_WR_ARB_BURST_EN
   assign lock_vec = bus.req_lock;
`else
   // Lock requests have no effect in the per-beat build
   logic unused_lock;
   assign lock_vec    = '0;
   assign unused_lock = ^bus.req_lock;
`endif

   fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Successor index modulo NUM_REQ
   function automatic logic [REQ_IDX_W-1:0] inc_idx(input logic [REQ_IDX_W-1:0] i);
      return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   assign full_now = (occ_q == OCC_W'(DEPTH));

   // Grant: owner only during a burst, RR winner otherwise; nothing while full
   always_comb begin
      ready = '0;
      if (!rst && !full_now) begin
         if (state_q == ST_BURST) begin
            ready[owner_q] = bus.req_valid[owner_q];
         end else if (pick_any) begin
            ready = pick_gnt;
         end
      end
   end

   assign win_idx = (state_q == ST_BURST) ? owner_q : pick_idx;
   assign xfer    = |(bus.req_valid & ready);
   assign pop     = bus.fifo_rd_en && (occ_q != '0);

   // Next-state: occupancy, write pipeline, error flag, RR pointer and FSM
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      beat_d      = beat_q;
      occ_d       = occ_q;
      underflow_d = underflow_q | (bus.fifo_rd_en && (occ_q == '0));
      wr_en_d     = xfer;
      wr_data_d   = wr_data_q;
      grant_id_d  = grant_id_q;

      if (xfer && !pop) begin
         occ_d = occ_q + 1'b1;
      end else if (!xfer && pop) begin
         occ_d = occ_q - 1'b1;
      end

      if (xfer) begin
         wr_data_d  = bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
         grant_id_d = win_idx;
      end

      // A full FIFO stalls the FSM: state and beat count hold
      if (!full_now) begin
         case (state_q)
            ST_IDLE: begin
               if (xfer) begin
                  ptr_d = inc_idx(win_idx);
                  if (lock_vec[win_idx]) begin
                     state_d = ST_BURST;
                     owner_d = win_idx;
                     beat_d  = BEAT_W'(1);
                  end
               end
            end
            ST_BURST: begin
               if (xfer) begin
                  beat_d = beat_q + 1'b1;
                  if (!lock_vec[owner_q] || (beat_q + 1'b1 == BEAT_W'(MAX_BURST))) begin
                     state_d = ST_IDLE;
                     ptr_d   = inc_idx(owner_q);
                     beat_d  = '0;
                  end
               end else if (!bus.req_valid[owner_q] && !lock_vec[owner_q]) begin
                  state_d = ST_IDLE;
                  ptr_d   = inc_idx(owner_q);
                  beat_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State registers; reset drops any accepted-but-unwritten beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         beat_q      <= '0;
         occ_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_data_q   <= '0;
         grant_id_q  <= '0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         beat_q      <= beat_d;
         occ_q       <= occ_d;
         wr_en_q     <= wr_en_d;
         wr_data_q   <= wr_data_d;
         grant_id_q  <= grant_id_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.req_ready     = ready;
   assign bus.fifo_wr_en    = wr_en_q;
   assign bus.fifo_wr_data  = wr_data_q;
   assign bus.occupancy     = occ_q;
   assign bus.full          = full_now;
   assign bus.grant_id      = grant_id_q;
   assign bus.underflow_err = underflow_q;
   assign bus.arb_state     = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: RR fill to full, pop/regrant, simultaneous
// push/pop, underflow, lock burst and mid-burst reset. Expectations follow the
// FIFO_WR_ARB_BURST_EN build selection.
module tb_fifo_wr_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4), .DEPTH(16)) bus ();

   fifo_wr_arbiter #(
      .DATA_WIDTH (8),
      .NUM_REQ    (4),
      .DEPTH      (16),
      .MAX_BURST  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next falling edge
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
      check_val({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'h0);
      check_val({tag, "_wr_data"}, 32'(bus.fifo_wr_data), 32'h0);
      check_val({tag, "_occ"}, 32'(bus.occupancy), 32'h0);
      check_val({tag, "_full"}, 32'(bus.full), 32'h0);
      check_val({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
      check_val({tag, "_underflow"}, 32'(bus.underflow_err), 32'h0);
   endtask

   logic [3:0] exp_rdy [5];
   logic [3:0] exp_beat2;

   initial begin
      total = 0;
      bad   = 0;
`ifdef FIFO_WR_ARB_BURST_EN
      exp_rdy   = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
      exp_beat2 = 4'b0100;
`else
      exp_rdy   = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
      exp_beat2 = 4'b1000;
`endif
      rst            = 1'b1;
      bus.req_valid  = '0;
      bus.req_lock   = '0;
      bus.req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      bus.fifo_rd_en = 1'b0;
      step();
      step();
      check_reset_vals("reset");

      // All producers valid, no lock: grants 0,1,2,3,... until full
      @(negedge clk);
      rst           = 1'b0;
      bus.req_valid = 4'hF;
      #1;
      for (int k = 0; k < 16; k++) begin
         check_val($sformatf("fill_ready_%0d", k), 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
         check_val($sformatf("fill_occ_%0d", k), 32'(bus.occupancy), 32'(k));
         check_val($sformatf("fill_wr_en_%0d", k), 32'(bus.fifo_wr_en), 32'(k != 0));
         if (k > 0)
            check_val($sformatf("fill_data_%0d", k), 32'(bus.fifo_wr_data), 32'(8'hA0 + (k - 1) % 4));
         step();
      end
      check_val("full_occ", 32'(bus.occupancy), 32'd16);
      check_val("full_flag", 32'(bus.full), 32'h1);
      check_val("full_ready", 32'(bus.req_ready), 32'h0);
      check_val("full_wr_en", 32'(bus.fifo_wr_en), 32'h1);
      check_val("full_wr_data", 32'(bus.fifo_wr_data), 32'hA3);
      check_val("full_grant_id", 32'(bus.grant_id), 32'h3);
      step();
      check_val("stall_wr_en", 32'(bus.fifo_wr_en), 32'h0);
      check_val("stall_occ", 32'(bus.occupancy), 32'd16);

      // Single pop from full: space appears next cycle, one grant to producer 0
      bus.fifo_rd_en = 1'b1;
      #1;
      check_val("pop_same_cycle_ready", 32'(bus.req_ready), 32'h0);
      step();
      bus.fifo_rd_en = 1'b0;
      #1;
      check_val("pop_occ", 32'(bus.occupancy), 32'd15);
      check_val("pop_full", 32'(bus.full), 32'h0);
      check_val("pop_regrant", 32'(bus.req_ready), 32'b0001);
      step();
      check_val("regrant_occ", 32'(bus.occupancy), 32'd16);
      check_val("regrant_ready", 32'(bus.req_ready), 32'h0);
      check_val("regrant_wr_data", 32'(bus.fifo_wr_data), 32'hA0);
      check_val("regrant_grant_id", 32'(bus.grant_id), 32'h0);

      // Drain to 8, then transfer and pop together
      bus.req_valid  = '0;
      bus.fifo_rd_en = 1'b1;
      repeat (8) step();
      check_val("drain8_occ", 32'(bus.occupancy), 32'd8);
      bus.req_valid = 4'b0010;
      #1;
      check_val("pushpop_ready", 32'(bus.req_ready), 32'b0010);
      step();
      check_val("pushpop_occ", 32'(bus.occupancy), 32'd8);
      check_val("pushpop_wr_data", 32'(bus.fifo_wr_data), 32'hA1);
      check_val("pushpop_grant_id", 32'(bus.grant_id), 32'h1);

      // Drain to empty, then pop on empty
      bus.req_valid = '0;
      repeat (8) step();
      check_val("empty_occ", 32'(bus.occupancy), 32'd0);
      check_val("empty_underflow", 32'(bus.underflow_err), 32'h0);
      step();
      check_val("underflow_occ", 32'(bus.occupancy), 32'd0);
      check_val("underflow_flag", 32'(bus.underflow_err), 32'h1);
      bus.fifo_rd_en = 1'b0;
      step();
      check_val("underflow_sticky", 32'(bus.underflow_err), 32'h1);

      // Producer 2 locks with pointer at 2
      bus.req_valid = 4'hF;
      bus.req_lock  = 4'b0100;
      #1;
      for (int b = 0; b < 5; b++) begin
         check_val($sformatf("burst_ready_%0d", b), 32'(bus.req_ready), 32'(exp_rdy[b]));
         step();
      end
      check_val("burst_occ", 32'(bus.occupancy), 32'd5);
      check_val("burst_underflow_sticky", 32'(bus.underflow_err), 32'h1);

      // Reset during beat 2 of a producer-2 burst
      bus.req_valid = 4'b0100;
      #1;
      check_val("rstburst_beat1", 32'(bus.req_ready), 32'b0100);
      step();
      bus.req_valid = 4'hF;
      #1;
      check_val("rstburst_beat2", 32'(bus.req_ready), 32'(exp_beat2));
`ifdef FIFO_WR_ARB_BURST_EN
      check_val("rstburst_state", 32'(bus.arb_state), 32'h1);
`endif
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      check_val("midrst_state", 32'(bus.arb_state), 32'h0);
      @(negedge clk);
      rst          = 1'b0;
      bus.req_lock = '0;
      #1;
      check_val("post_rst_ready", 32'(bus.req_ready), 32'b0001);
      step();
      check_val("post_rst_wr_en", 32'(bus.fifo_wr_en), 32'h1);
      check_val("post_rst_wr_data", 32'(bus.fifo_wr_data), 32'hA0);
      check_val("post_rst_occ", 32'(bus.occupancy), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
